// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide controller: op encodings, FSM states,
// divider iteration count, divide-by-zero quotient and an operand magnitude helper.
// Optional feature macro: MDU_MUL_MC_EN (adds the MUL_WAIT state).
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
`ifdef MDU_MUL_MC_EN
        ST_MUL_WAIT = 2'd1,
`endif
        ST_DIV_RUN  = 2'd2,
        ST_DONE     = 2'd3
    } mdu_state_t;

    // Magnitude of a possibly-signed operand; 0x8000_0000 maps onto itself,
    // which read as unsigned is exactly 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// Purpose : one radix-2 restoring divide iteration on {rem,quo} against the divisor.
// Latency : purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports   : i_rem/i_quo current partial remainder and dividend/quotient shift register,
//           i_dvsr divisor magnitude; o_rem/o_quo the values after this step.
module div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_dvsr,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_sh;
    logic        w_ge;

    // The shifted remainder needs 33 bits: with an unsigned divisor above 2^31
    // the remainder can exceed 2^31 before the shift.
    assign w_sh  = {i_rem, i_quo[31]};
    assign w_ge  = (w_sh >= {1'b0, i_dvsr});
    // After a successful subtract the result is below the divisor, so 32 bits suffice.
    assign o_rem = w_ge ? 32'(w_sh - {1'b0, i_dvsr}) : w_sh[31:0];
    assign o_quo = {i_quo[30:0], w_ge};

endmodule

// File: rtl/mdu_ctrl.sv
// Purpose : E-stage MULT/MULTU/DIV/DIVU controller with a 32-step restoring divider.
// Latency : DIV result in the 34th cycle (33 stall cycles); MULT same cycle, or one
//           stall cycle then result when MDU_MUL_MC_EN is defined.
// Backpressure: stall_o holds the E-stage instruction; flush_i aborts with no result.
// Ports   : clk/rst (async active-high); op_valid_i/op_i/a_i/b_i the E-stage op and
//           operands; flush_i abort; stall_o E stall; result_valid_o/hi_o/lo_o HI/LO result.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int DIV_ITERS = mdu_pkg::DIV_ITERS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        result_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    mdu_state_t  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
`ifdef MDU_MUL_MC_EN
    logic [63:0] r_prod;
`endif

    logic        w_is_div;
    logic        w_signed;
    logic [63:0] w_prod;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_is_div = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    assign w_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);

    // Sign-extend to 64 bits; the low 64 bits of the product are then correct
    // for both signed and unsigned operands.
    assign w_prod = {{32{w_signed & a_i[31]}}, a_i} * {{32{w_signed & b_i[31]}}, b_i};

    div_step u_div_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dvsr (r_dvsr),
        .o_rem  (w_rem_nxt),
        .o_quo  (w_quo_nxt)
    );

    // With a zero divisor every trial subtract succeeds, so the remainder ends
    // holding |a|; re-applying the dividend sign returns a_i unchanged for HI.
    assign w_q_fix = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign w_r_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;

    always_comb begin
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        hi_o           = 32'd0;
        lo_o           = 32'd0;
        if (!rst && !flush_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (op_valid_i) begin
                        if (w_is_div) begin
                            stall_o = 1'b1;
                        end else begin
`ifdef MDU_MUL_MC_EN
                            stall_o = 1'b1;
`else
                            result_valid_o = 1'b1;
                            hi_o           = w_prod[63:32];
                            lo_o           = w_prod[31:0];
`endif
                        end
                    end
                end
`ifdef MDU_MUL_MC_EN
                ST_MUL_WAIT: begin
                    result_valid_o = 1'b1;
                    hi_o           = r_prod[63:32];
                    lo_o           = r_prod[31:0];
                end
`endif
                ST_DIV_RUN: stall_o = 1'b1;
                ST_DONE: begin
                    result_valid_o = 1'b1;
                    hi_o           = w_r_fix;
                    lo_o           = r_dz ? DIV0_LO : w_q_fix;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_dvsr  <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
`ifdef MDU_MUL_MC_EN
            r_prod  <= 64'd0;
`endif
        end else if (flush_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_valid_i && w_is_div) begin
                        r_rem   <= 32'd0;
                        r_quo   <= mag32(a_i, w_signed);
                        r_dvsr  <= mag32(b_i, w_signed);
                        r_neg_q <= w_signed & (a_i[31] ^ b_i[31]);
                        r_neg_r <= w_signed & a_i[31];
                        r_dz    <= (b_i == 32'd0);
                        r_cnt   <= 5'd0;
                        r_state <= ST_DIV_RUN;
                    end
`ifdef MDU_MUL_MC_EN
                    else if (op_valid_i) begin
                        r_prod  <= w_prod;
                        r_state <= ST_MUL_WAIT;
                    end
`endif
                end
`ifdef MDU_MUL_MC_EN
                ST_MUL_WAIT: r_state <= ST_IDLE;
`endif
                ST_DIV_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(DIV_ITERS - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                // The instruction leaves E at the end of DONE, so never restart here.
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: reset, multiplies, divides (signed/unsigned,
// divide-by-zero, extremes), back-to-back divides, flush and reset mid-run.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        result_valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.DIV_ITERS(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .op_valid_i     (op_valid_i),
        .op_i           (op_i),
        .a_i            (a_i),
        .b_i            (b_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .hi_o           (hi_o),
        .lo_o           (lo_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with op_valid_i low.
    task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
        op_valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
`ifdef MDU_MUL_MC_EN
        @(negedge clk);
        check({tag, "_stall1"}, 32'(stall_o), 32'd1);
        check({tag, "_vld0"}, 32'(result_valid_o), 32'd0);
        @(posedge clk); #1;
`endif
        @(negedge clk);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_vld"}, 32'(result_valid_o), 32'd1);
        check({tag, "_hi"}, hi_o, exp_hi);
        check({tag, "_lo"}, lo_o, exp_lo);
        @(posedge clk); #1;
        op_valid_i = 1'b0;
    endtask

    // Called at posedge+1; counts stall cycles, checks the DONE cycle, returns at posedge+1.
    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
        int n = 0;
        op_valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        while (stall_o === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_stalls"}, 32'(n), 32'd33);
        check({tag, "_vld"}, 32'(result_valid_o), 32'd1);
        check({tag, "_hi"}, hi_o, exp_hi);
        check({tag, "_lo"}, lo_o, exp_lo);
        @(posedge clk); #1;
        op_valid_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op_valid_i = 1'b0; flush_i = 1'b0; op_i = 2'b00; a_i = 32'd0; b_i = 32'd0;
        @(negedge clk);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_vld", 32'(result_valid_o), 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_mul(MDU_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
        run_mul(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, "multu");

        @(negedge clk);
        check("idle_vld", 32'(result_valid_o), 32'd0);
        check("idle_hi", hi_o, 32'd0);
        check("idle_lo", lo_o, 32'd0);
        @(posedge clk); #1;

        run_div(MDU_DIVU, 32'd100,        32'd7,          32'd2,          32'd14,         "divu_100_7");
        run_div(MDU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  "div_m7_2");
        run_div(MDU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  "div_min_m1");
        run_div(MDU_DIV,  32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  "div_7_m2");
        run_div(MDU_DIV,  32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  "div_5_0");
        run_div(MDU_DIVU, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFF0,  32'hFFFF_FFFF,  "divu_x_0");
        // Back-to-back: the second divide is presented in the cycle right after DONE.
        run_div(MDU_DIVU, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          "divu_big");
        run_div(MDU_DIVU, 32'hFFFF_FFFF,  32'd10,         32'd5,          32'h1999_9999,  "divu_b2b");

        // Flush in the tenth run cycle.
        op_valid_i = 1'b1; op_i = MDU_DIVU; a_i = 32'd100; b_i = 32'd7;
        @(negedge clk);
        check("fl_accept_stall", 32'(stall_o), 32'd1);
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        check("fl_stall", 32'(stall_o), 32'd0);
        check("fl_vld", 32'(result_valid_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; op_valid_i = 1'b0;
        @(negedge clk);
        check("fl_after_stall", 32'(stall_o), 32'd0);
        check("fl_after_vld", 32'(result_valid_o), 32'd0);
        @(posedge clk); #1;
        run_div(MDU_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, "divu_9_3");

        // Flush together with a new op in IDLE starts nothing.
        op_valid_i = 1'b1; op_i = MDU_DIV; a_i = 32'd50; b_i = 32'd5; flush_i = 1'b1;
        @(negedge clk);
        check("flidle_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; op_valid_i = 1'b0;
        @(negedge clk);
        check("flidle_after_stall", 32'(stall_o), 32'd0);
        check("flidle_after_vld", 32'(result_valid_o), 32'd0);
        @(posedge clk); #1;

        // Reset pulsed mid-run: outputs drop at once, even with the op still presented.
        op_valid_i = 1'b1; op_i = MDU_DIV; a_i = 32'd100; b_i = 32'd7;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rstrun_stall", 32'(stall_o), 32'd0);
        check("rstrun_vld", 32'(result_valid_o), 32'd0);
        check("rstrun_hi", hi_o, 32'd0);
        check("rstrun_lo", lo_o, 32'd0);
        op_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstrun_after_stall", 32'(stall_o), 32'd0);
        check("rstrun_after_vld", 32'(result_valid_o), 32'd0);
        @(posedge clk); #1;
        run_div(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_after_rst");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide controller for the execute stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from E and sequences a radix-2 restoring divider over 32 iterations. While a divide runs, it raises the execute-stage stall consumed by the hazard unit as `mut_div_stallE`. It then presents the HI/LO result for one cycle so the pipeline carries it to M, where HI/LO is written.

## Interface
Parameters:
- `DIV_ITERS`, 32: divider iterations; fixed for 32-bit operands.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `op_valid_i`  in  1  E-stage instruction is an MDU op; held stable while `stall_o`=1.
- `op_i`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a_i`  in  32  rs operand (dividend), already forwarded.
- `b_i`  in  32  rt operand (divisor).
- `flush_i`  in  1  exception flush; aborts any operation.
- `stall_o`  out  1  E-stage stall (drives `mut_div_stallE`).
- `result_valid_o`  out  1  HI/LO result valid this cycle.
- `hi_o`  out  32  HI result (remainder / product high).
- `lo_o`  out  32  LO result (quotient / product low).

## Operation
- States: IDLE, MUL_WAIT (only with `MDU_MUL_MC_EN`), DIV_RUN, DONE.
- IDLE, `op_valid_i`, DIV/DIVU, no flush:
  - Latch |a|, |b|, the sign flags and the zero-divisor flag.
  - Clear the 5-bit counter, go to DIV_RUN.
  - `stall_o`=1 combinationally in this cycle.
- IDLE, MULT/MULTU, macro off: 64-bit product computed combinationally; `result_valid_o`=1 and `stall_o`=0 in the same cycle; stay IDLE.
- DIV_RUN:
  - One restoring step per cycle; counter increments.
  - After the step with counter==31, go to DONE.
  - `stall_o`=1 throughout.
- DONE:
  - `stall_o`=0, `result_valid_o`=1.
  - Quotient negated if the operand signs differ (DIV only); remainder takes the dividend's sign (DIV only).
  - Next state is always IDLE. The instruction leaves E at the end of this cycle, so no restart occurs.
- Divide by zero: full 33-cycle sequence, then HI=`a_i` as latched and LO=32'hFFFF_FFFF, for both DIV and DIVU.
- `flush_i` has priority in every state:
  - `stall_o` and `result_valid_o` forced 0 in that cycle.
  - Next state IDLE, no result.
  - `flush_i` with `op_valid_i` in IDLE starts nothing.
- `hi_o`/`lo_o` are 0 whenever `result_valid_o`=0.
- Signed magnitudes: the 0x8000_0000 operand is handled as the unsigned magnitude 2^31.

## Timing
- Reset (async): state IDLE, counter 0; `stall_o`=0, `result_valid_o`=0, `hi_o`=`lo_o`=0.
- Reset mid-operation abandons the divide with no result.
- DIV latency: accept cycle plus 32 run cycles with `stall_o`=1 (33 stall cycles total). The result appears in the 34th cycle (DONE), counting the accept cycle as 1.
- MULT latency: 0 extra cycles with the macro off; 1 stall cycle with it on.
- `stall_o` is combinational from state, `op_valid_i`, `op_i` and `flush_i`. It has no path from `a_i`/`b_i`.
- Back-to-back DIVs: the second is accepted in the cycle after DONE, because IDLE sees the new E instruction.

## Configuration
- `MDU_MUL_MC_EN` defined:
  - MULT/MULTU in IDLE asserts `stall_o` for 1 cycle and registers the product, then enters MUL_WAIT.
  - MUL_WAIT drives `result_valid_o`=1 with `stall_o`=0, then returns to IDLE.
  - This removes the 32x32 multiplier from the E critical path.
- Undefined: MUL_WAIT does not exist; multiply is single-cycle and combinational.

## Structure
- `mdu_pkg` holds:
  - op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - the state enum;
  - `DIV_ITERS`;
  - the divide-by-zero LO constant.
- Sub-module `div_step`: one combinational restoring iteration (shift {rem,quo}, trial subtract, select). It is instantiated once and driven by the state registers.

## Test plan
- MULT a=0xFFFFFFFF, b=2 -> same cycle `result_valid_o`=1, HI=0xFFFFFFFF, LO=0xFFFFFFFE, `stall_o`=0. With the macro: 1 stall cycle, then the same result.
- MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIVU a=100, b=7 -> `stall_o`=1 for exactly 33 cycles, then one cycle with LO=14, HI=2 and `result_valid_o`=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV a=5, b=0 -> 33 stall cycles, then HI=5, LO=0xFFFFFFFF.
- `flush_i` at run cycle 10 -> `stall_o`=0 that cycle, IDLE next, no `result_valid_o`; a following DIVU 9/3 returns LO=3, HI=0. Repeat with `rst` pulsed mid-run: outputs 0 immediately.
